sme_result_drain: RTL and testbench
===================================

# sme_result_drain

Host-side return path of the SME datapath: accepts per-share results (`sme_result_t` plus share index) from the SME pipeline, checks share ordering, buffers them in a small FIFO and presents them to the host write-back stage under a valid/ready handshake. It also tracks the destination share register of the one in-flight SME instruction, so that issue logic can interlock on it. It sits between the SME execute pipeline and the host writeback stage, at the opposite end of the issue path that carries `sme_data_t`.

## Interface
- `DEPTH`, 4, result FIFO entries; power of two, ≥2.
- `g_clk`  in  1  clock.
- `g_resetn`  in  1  asynchronous reset, active-low.
- `smectl_nshares`  in  4  share count `smectl[8:5]`; sampled only on an issue handshake.
- `iss_valid`  in  1  SME instruction issued this cycle.
- `iss_rd_addr`  in  4  destination share register of the issued instruction.
- `iss_ready`  out  1  high when no SME instruction is in flight (state IDLE).
- `sb_busy`  out  16  one-hot busy vector, indexed by `rd_addr`.
- `sme_valid`  in  1  result beat from the SME pipeline.
- `sme_result`  in  `sme_result_t`  result beat (`rd_wdata`, `rd_addr`).
- `sme_share`  in  4  share index of the beat.
- `sme_ready`  out  1  equals `!full`; independent of `hst_ready`.
- `hst_valid`  out  1  FIFO head is valid.
- `hst_result`  out  `sme_result_t`  FIFO head.
- `hst_share`  out  4  share index of the head.
- `hst_last`  out  1  head is the final share of its instruction.
- `err_order`  out  1  one-cycle pulse on a dropped beat.

## Operation
- Reset values: `iss_ready`=1, `sb_busy`=0, `sme_ready`=1, `hst_valid`=0, `hst_result`/`hst_share`/`hst_last`=0, `err_order`=0. State is IDLE, the FIFO is empty and all counters are 0.
- States:
  - IDLE → COLLECT on `iss_valid && iss_ready`.
  - COLLECT → DRAIN when the last share is pushed.
  - DRAIN → IDLE when the `hst_last` entry pops.
- Issue:
  - Latch `nsh = (smectl_nshares==0) ? 1 : smectl_nshares`.
  - Latch `rd = iss_rd_addr`.
  - Set `sb_busy[rd]`.
  - Clear the expected-share counter `exp` to 0.
  - `iss_valid` while not `iss_ready` is ignored.
- Beat accepted (`sme_valid && sme_ready`) in COLLECT with `sme_share==exp` and `sme_result.rd_addr==rd`:
  - Push `{result, share, last = (exp==nsh-1)}`.
  - Advance `exp`: 4-bit, wraps to 0 after `nsh-1`.
- Beat accepted in IDLE or DRAIN, or with a wrong share index or wrong `rd_addr`:
  - Consumed but not pushed.
  - `exp` unchanged.
  - `err_order` pulses the next cycle.
- Pop on `hst_valid && hst_ready`. When the popped entry has `hst_last`, clear `sb_busy[rd]` in the same edge.
- Push and pop in the same cycle: occupancy is unchanged, which is legal at any occupancy below full.
- At full, `sme_ready`=0 even if a pop occurs that cycle; there is no combinational ready path.
- Pointers are `log2(DEPTH)` bits wide and wrap naturally. Occupancy is `log2(DEPTH)+1` bits.
- Reset asserted mid-operation discards all FIFO contents, the scoreboard and the in-flight state immediately (asynchronous).

## Timing
- Accepted beat → `hst_valid` high at the next rising edge. Minimum latency is 1 cycle.
- Head outputs are registered from FIFO storage and stay stable while `hst_valid && !hst_ready`.
- `iss_ready` rises the cycle after the last pop.
- Back-to-back throughput:
  - Issue-to-issue is at least `nsh+2` cycles.
  - Sustained throughput is one beat per cycle with `hst_ready` held high.
- `sb_busy[rd]` rises at the issue edge and falls at the last-pop edge.

## Structure
- Add to `sme_pkg`:
  - `sme_rsp_t` packed `{sme_result_t res; logic [3:0] share; logic last;}`.
  - A function `sme_nshares(smectl)` returning the clamped count.
- The state enum (IDLE/COLLECT/DRAIN) is local to the block.
- Sub-module `sme_rsp_fifo`: a parameterised synchronous FIFO of `sme_rsp_t` with full/empty outputs. It is instantiated once. Control, the share counter and the scoreboard live in the top level.

## Test plan
- Set `nshares`=3 and issue `rd`=5, then push shares 0,1,2 with `rd_wdata` `0xA0`,`0xA1`,`0xA2`, holding `hst_ready`=1:
  - Host sees three beats in order.
  - `hst_last` is set only on `0xA2`.
  - `sb_busy` is `0x0020` and falls after the third pop.
  - `iss_ready` returns high the following cycle.
- `DEPTH`=4 with `nshares`=6 and `hst_ready`=0:
  - After 4 pushes `sme_ready`=0.
  - Raise `hst_ready` for one cycle: exactly one pop occurs, and `sme_ready` rises the next cycle.
  - All 6 shares finally arrive in order with no loss.
- In COLLECT, expecting share 1, send share 2 (`0xBB`):
  - `err_order` pulses once.
  - Nothing is pushed.
  - A subsequent share 1 is accepted normally.
- Send a beat while IDLE:
  - `sme_ready`=1 and the beat is consumed.
  - `err_order` pulses.
  - `hst_valid` stays 0.
- `smectl_nshares`=0 at issue: a single share-0 beat completes the instruction with `hst_last`=1.
- Assert `g_resetn` low with 2 entries buffered and `sb_busy[9]` set: all outputs return to their reset values asynchronously, and no beat is presented after release.

Source files
------------

// File: rtl/sme_pkg.sv
// Shared types for the SME datapath: result beats returned to the host and the
// buffered response entry that carries share ordering information.
package sme_pkg;

   localparam int SME_XLEN   = 32;
   localparam int SME_NREGS  = 16;

   typedef struct packed {
      logic [SME_XLEN-1:0] rd_wdata;
      logic [3:0]          rd_addr;
   } sme_result_t;

   typedef struct packed {
      sme_result_t res;
      logic [3:0]  share;
      logic        last;
   } sme_rsp_t;

   // A programmed share count of zero means a single (unmasked) share.
   function automatic logic [3:0] sme_nshares(input logic [3:0] nshares);
      return (nshares == 4'd0) ? 4'd1 : nshares;
   endfunction

endpackage

// File: rtl/sme_rsp_fifo.sv
// Synchronous FIFO of response entries. Head is read straight out of the
// storage registers, so it is stable for as long as it is not popped.
module sme_rsp_fifo
   import sme_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push,
   input  sme_rsp_t push_data,
   input  logic     pop,
   output sme_rsp_t head,
   output logic     full,
   output logic     empty
);

   localparam int AW = $clog2(DEPTH);

   sme_rsp_t        mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sme_result_drain.sv
// Host-side return path of the SME datapath: order-checks per-share results,
// buffers them for the host and tracks the in-flight destination register.
module sme_result_drain
   import sme_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        g_clk,
   input  logic        g_resetn,
   input  logic [3:0]  smectl_nshares,
   input  logic        iss_valid,
   input  logic [3:0]  iss_rd_addr,
   output logic        iss_ready,
   output logic [15:0] sb_busy,
   input  logic        sme_valid,
   input  sme_result_t sme_result,
   input  logic [3:0]  sme_share,
   output logic        sme_ready,
   output logic        hst_valid,
   input  logic        hst_ready,
   output sme_result_t hst_result,
   output logic [3:0]  hst_share,
   output logic        hst_last,
   output logic        err_order
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; ready never depends combinationally on the far side's ready.

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_DRAIN   = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  nsh;
   logic [3:0]  rd;
   logic [3:0]  exp_share;
   logic        issue;
   logic        beat;
   logic        beat_ok;
   logic        beat_last;
   logic        pop;
   logic        pop_last;
   logic        full;
   logic        empty;
   sme_rsp_t    push_data;
   sme_rsp_t    head;

   always_comb begin
      issue     = iss_valid && (state == ST_IDLE);
      beat      = sme_valid && !full;
      beat_ok   = beat && (state == ST_COLLECT) && (sme_share == exp_share)
                  && (sme_result.rd_addr == rd);
      beat_last = (exp_share == nsh - 4'd1);
      pop       = !empty && hst_ready;
      pop_last  = pop && head.last;
      push_data = '{res: sme_result, share: sme_share, last: beat_last};
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    if (issue) state_nxt = ST_COLLECT;
         ST_COLLECT: if (beat_ok && beat_last) state_nxt = ST_DRAIN;
         ST_DRAIN:   if (pop_last) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         state     <= ST_IDLE;
         nsh       <= 4'd1;
         rd        <= '0;
         exp_share <= '0;
         sb_busy   <= '0;
         err_order <= 1'b0;
      end else begin
         state     <= state_nxt;
         err_order <= beat && !beat_ok;
         if (issue) begin
            nsh       <= sme_nshares(smectl_nshares);
            rd        <= iss_rd_addr;
            exp_share <= '0;
         end else if (beat_ok) begin
            exp_share <= beat_last ? 4'd0 : exp_share + 4'd1;
         end
         // Issue only happens in IDLE and the last pop only in DRAIN,
         // so the set and the clear never collide.
         if (issue) begin
            sb_busy[iss_rd_addr] <= 1'b1;
         end else if (pop_last) begin
            sb_busy[rd] <= 1'b0;
         end
      end
   end

   sme_rsp_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (g_clk),
      .rst_n     (g_resetn),
      .push      (beat_ok),
      .push_data (push_data),
      .pop       (pop),
      .head      (head),
      .full      (full),
      .empty     (empty)
   );

   assign iss_ready  = (state == ST_IDLE);
   assign sme_ready  = !full;
   assign hst_valid  = !empty;
   assign hst_result = head.res;
   assign hst_share  = head.share;
   assign hst_last   = head.last;

endmodule

// File: tb/tb_sme_result_drain.sv
// Randomised and directed bench for sme_result_drain against a queue-based
// reference model of the instruction/share protocol.
module tb_sme_result_drain;
   import sme_pkg::*;

   localparam int DEPTH = 4;

   logic        g_clk;
   logic        g_resetn;
   logic [3:0]  smectl_nshares;
   logic        iss_valid;
   logic [3:0]  iss_rd_addr;
   logic        iss_ready;
   logic [15:0] sb_busy;
   logic        sme_valid;
   sme_result_t sme_result;
   logic [3:0]  sme_share;
   logic        sme_ready;
   logic        hst_valid;
   logic        hst_ready;
   sme_result_t hst_result;
   logic [3:0]  hst_share;
   logic        hst_last;
   logic        err_order;

   sme_result_drain #(.DEPTH(DEPTH)) dut (
      .g_clk          (g_clk),
      .g_resetn       (g_resetn),
      .smectl_nshares (smectl_nshares),
      .iss_valid      (iss_valid),
      .iss_rd_addr    (iss_rd_addr),
      .iss_ready      (iss_ready),
      .sb_busy        (sb_busy),
      .sme_valid      (sme_valid),
      .sme_result     (sme_result),
      .sme_share      (sme_share),
      .sme_ready      (sme_ready),
      .hst_valid      (hst_valid),
      .hst_ready      (hst_ready),
      .hst_result     (hst_result),
      .hst_share      (hst_share),
      .hst_last       (hst_last),
      .err_order      (err_order)
   );

   // clock
   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   // reference model
   sme_rsp_t    exp_q[$];
   logic [15:0] m_busy;
   bit          m_inflight;
   bit          m_collecting;
   int          m_nsh;
   int          m_next;
   logic [3:0]  m_rd;
   bit          m_err;

   int n_vec;
   int n_err;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_busy       = '0;
      m_inflight   = 0;
      m_collecting = 0;
      m_nsh        = 1;
      m_next       = 0;
      m_rd         = '0;
      m_err        = 0;
   endtask

   task automatic compare_all();
      check("iss_ready", iss_ready, !m_inflight);
      check("sb_busy", sb_busy, m_busy);
      check("sme_ready", sme_ready, exp_q.size() < DEPTH);
      check("hst_valid", hst_valid, exp_q.size() != 0);
      check("err_order", err_order, m_err);
      if (exp_q.size() != 0) begin
         check("hst_wdata", hst_result.rd_wdata, exp_q[0].res.rd_wdata);
         check("hst_addr", hst_result.rd_addr, exp_q[0].res.rd_addr);
         check("hst_share", hst_share, exp_q[0].share);
         check("hst_last", hst_last, exp_q[0].last);
      end
   endtask

   task automatic check_reset_values();
      check("rst_iss_ready", iss_ready, 1'b1);
      check("rst_sb_busy", sb_busy, 16'h0000);
      check("rst_sme_ready", sme_ready, 1'b1);
      check("rst_hst_valid", hst_valid, 1'b0);
      check("rst_hst_result", hst_result, '0);
      check("rst_hst_share", hst_share, 4'h0);
      check("rst_hst_last", hst_last, 1'b0);
      check("rst_err_order", err_order, 1'b0);
   endtask

   // Called at a falling edge: drive one cycle of inputs, advance the model
   // across the rising edge, then compare at the next falling edge.
   task automatic tick(input logic iv, input logic [3:0] ira, input logic [3:0] nsh,
                       input logic sv, input logic [31:0] wd, input logic [3:0] ra,
                       input logic [3:0] sh, input logic hr);
      bit       was_idle;
      bit       pop;
      bit       acc;
      sme_rsp_t r;
      iss_valid           = iv;
      iss_rd_addr         = ira;
      smectl_nshares      = nsh;
      sme_valid           = sv;
      sme_result.rd_wdata = wd;
      sme_result.rd_addr  = ra;
      sme_share           = sh;
      hst_ready           = hr;

      was_idle = !m_inflight;
      pop      = (exp_q.size() != 0) && hr;
      acc      = sv && (exp_q.size() < DEPTH);
      m_err    = 0;
      if (pop) begin
         r = exp_q.pop_front();
         if (r.last) begin
            m_busy[m_rd] = 1'b0;
            m_inflight   = 0;
         end
      end
      if (acc) begin
         if (m_collecting && (int'(sh) == m_next) && (ra == m_rd)) begin
            r.res.rd_wdata = wd;
            r.res.rd_addr  = ra;
            r.share        = sh;
            r.last         = (m_next == m_nsh - 1);
            exp_q.push_back(r);
            m_next++;
            if (r.last) m_collecting = 0;
         end else begin
            m_err = 1;
         end
      end
      if (iv && was_idle) begin
         m_inflight   = 1;
         m_collecting = 1;
         m_nsh        = (nsh == 0) ? 1 : int'(nsh);
         m_next       = 0;
         m_rd         = ira;
         m_busy[ira]  = 1'b1;
      end

      @(posedge g_clk);
      @(negedge g_clk);
      compare_all();
   endtask

   task automatic idle(input logic hr);
      tick(1'b0, 4'h0, 4'h0, 1'b0, 32'h0, 4'h0, 4'h0, hr);
   endtask

   task automatic beat(input logic [31:0] wd, input logic [3:0] ra, input logic [3:0] sh, input logic hr);
      tick(1'b0, 4'h0, 4'h0, 1'b1, wd, ra, sh, hr);
   endtask

   task automatic issue(input logic [3:0] rd, input logic [3:0] nsh, input logic hr);
      tick(1'b1, rd, nsh, 1'b0, 32'h0, 4'h0, 4'h0, hr);
   endtask

   task automatic random_tick();
      logic       iv;
      logic [3:0] ira;
      logic [3:0] nsh;
      logic       sv;
      logic [3:0] ra;
      logic [3:0] sh;
      iv  = ($urandom_range(0, 3) == 0);
      ira = 4'($urandom_range(0, 15));
      nsh = 4'($urandom_range(0, 6));
      sv  = ($urandom_range(0, 2) != 0);
      if (m_collecting && ($urandom_range(0, 9) != 0)) begin
         sh = 4'(m_next);
         ra = m_rd;
      end else begin
         sh = 4'($urandom_range(0, 15));
         ra = 4'($urandom_range(0, 15));
      end
      tick(iv, ira, nsh, sv, $urandom, ra, sh, $urandom_range(0, 3) != 0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      model_reset();
      iss_valid      = 1'b0;
      iss_rd_addr    = '0;
      smectl_nshares = '0;
      sme_valid      = 1'b0;
      sme_result     = '0;
      sme_share      = '0;
      hst_ready      = 1'b0;

      // reset
      g_resetn = 1'b1;
      #1 g_resetn = 1'b0;
      #1 check_reset_values();
      @(posedge g_clk);
      @(negedge g_clk);
      g_resetn = 1'b1;
      compare_all();

      // three shares to rd=5 with the host always ready
      issue(4'd5, 4'd3, 1'b1);
      check("t1_busy", sb_busy, 16'h0020);
      beat(32'hA0, 4'd5, 4'd0, 1'b1);
      beat(32'hA1, 4'd5, 4'd1, 1'b1);
      check("t1_last_a1", hst_last, 1'b0);
      beat(32'hA2, 4'd5, 4'd2, 1'b1);
      check("t1_data_a2", hst_result.rd_wdata, 32'hA2);
      check("t1_last_a2", hst_last, 1'b1);
      idle(1'b1);
      check("t1_busy_clr", sb_busy, 16'h0000);
      check("t1_iss_ready", iss_ready, 1'b1);
      idle(1'b1);

      // six shares through a four-entry FIFO with the host stalled
      issue(4'd3, 4'd6, 1'b0);
      for (int i = 0; i < 4; i++) beat(32'hC0 + 32'(i), 4'd3, 4'(i), 1'b0);
      check("t2_full", sme_ready, 1'b0);
      beat(32'hC4, 4'd3, 4'd4, 1'b0);
      beat(32'hC4, 4'd3, 4'd4, 1'b1);
      check("t2_ready_back", sme_ready, 1'b1);
      check("t2_head_share", hst_share, 4'd1);
      beat(32'hC4, 4'd3, 4'd4, 1'b0);
      idle(1'b1);
      beat(32'hC5, 4'd3, 4'd5, 1'b1);
      for (int i = 0; i < 6; i++) idle(1'b1);
      check("t2_drained", hst_valid, 1'b0);

      // out-of-order share is dropped
      issue(4'd7, 4'd3, 1'b1);
      beat(32'hB0, 4'd7, 4'd0, 1'b1);
      beat(32'hBB, 4'd7, 4'd2, 1'b1);
      check("t3_err", err_order, 1'b1);
      beat(32'hB1, 4'd7, 4'd1, 1'b1);
      check("t3_err_once", err_order, 1'b0);
      check("t3_share1", hst_share, 4'd1);
      beat(32'hB2, 4'd7, 4'd2, 1'b1);
      for (int i = 0; i < 3; i++) idle(1'b1);

      // beat while idle
      beat(32'hDD, 4'd0, 4'd0, 1'b1);
      check("t4_err", err_order, 1'b1);
      check("t4_no_push", hst_valid, 1'b0);
      idle(1'b1);

      // nshares of zero means a single share
      issue(4'd2, 4'd0, 1'b0);
      beat(32'hE0, 4'd2, 4'd0, 1'b0);
      check("t5_last", hst_last, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // asynchronous reset with two entries buffered
      issue(4'd9, 4'd4, 1'b0);
      beat(32'hF0, 4'd9, 4'd0, 1'b0);
      beat(32'hF1, 4'd9, 4'd1, 1'b0);
      check("t6_busy9", sb_busy, 16'h0200);
      #2 g_resetn = 1'b0;
      #1 check_reset_values();
      model_reset();
      iss_valid = 1'b0;
      sme_valid = 1'b0;
      @(posedge g_clk);
      @(negedge g_clk);
      g_resetn = 1'b1;
      compare_all();
      for (int i = 0; i < 3; i++) idle(1'b1);

      // randomised traffic
      for (int i = 0; i < 3000; i++) random_tick();
      for (int i = 0; i < 12; i++) idle(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
